// File: rtl/datapath.sv
// rtl/datapath.sv - single-bus 32-bit CPU datapath (16 GP regs, PC, IR, Y, Z, HI, LO, MDR, MAR, ALU)
//
// Purpose: one shared 32-bit bus driven by a source select. Every register loads from that bus
// (or from the ALU for Z, or from Mdatain for MDR) on the rising clock edge when its enable is high.
//
// Ports:
//   clock          in   1   single clock, rising edge
//   clear          in   1   synchronous active-high reset, beats all enables
//   incPC          in   1   ALU override: Z = {32'h0, bus + 1}
//   GP_addr        in   4   GP register write address
//   Mdatain        in   32  memory read data
//   MDR_read       in   1   MDR source: 1 = Mdatain, 0 = bus
//   e_PC/e_IR/e_Y  in   1   load PC / IR / Y from bus
//   e_Z            in   1   load Z from the ALU result
//   e_HI/e_LO      in   1   load HI / LO from bus
//   e_MDR/e_MAR    in   1   load MDR (muxed) / MAR (bus)
//   e_GP           in   1   load R[GP_addr] from bus
//   ALU_op         in   4   ALU operation, A = Y, B = bus
//   BusDataSelect  in   5   bus source select
//   BusMuxOut      out  32  current bus value
//   PC_out, IR_out, MAR_out, HI_out, LO_out  out 32  register contents
//
// Configuration: define DATAPATH_DIV_EN to build the signed divider (ALU_op 0110);
// without it op 0110 produces Z = 0.

module datapath (
  input  logic        clock,
  input  logic        clear,
  input  logic        incPC,
  input  logic [3:0]  GP_addr,
  input  logic [31:0] Mdatain,
  input  logic        MDR_read,
  input  logic        e_PC,
  input  logic        e_IR,
  input  logic        e_Y,
  input  logic        e_Z,
  input  logic        e_HI,
  input  logic        e_LO,
  input  logic        e_MDR,
  input  logic        e_MAR,
  input  logic        e_GP,
  input  logic [3:0]  ALU_op,
  input  logic [4:0]  BusDataSelect,
  output logic [31:0] BusMuxOut,
  output logic [31:0] PC_out,
  output logic [31:0] IR_out,
  output logic [31:0] MAR_out,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out
);

  logic [31:0] gp [16];
  logic [31:0] pc, ir, y, hi, lo, mdr, mar;
  logic [63:0] z;
  logic [31:0] bus;
  logic [63:0] alu_res;

  // Bus source mux; selects 22-31 read as zero.
  always_comb begin
    bus = '0;
    if (!BusDataSelect[4]) begin
      bus = gp[BusDataSelect[3:0]];
    end else begin
      case (BusDataSelect[3:0])
        4'd0:    bus = hi;
        4'd1:    bus = lo;
        4'd2:    bus = z[63:32];
        4'd3:    bus = z[31:0];
        4'd4:    bus = pc;
        4'd5:    bus = mdr;
        default: bus = '0;
      endcase
    end
  end

  // Sign-extended operands so MUL (and DIV) are computed exactly in 64 bits.
  logic signed [63:0] a_sx, b_sx;
  logic        [4:0]  shamt;
  logic        [31:0] y_sra;
  assign a_sx  = {{32{y[31]}}, y};
  assign b_sx  = {{32{bus[31]}}, bus};
  assign shamt = bus[4:0];
  assign y_sra = $signed(y) >>> shamt;

`ifdef DATAPATH_DIV_EN
  // 64-bit divide keeps the -2^31 / -1 case well defined (quotient wraps to 32'h8000_0000).
  logic [31:0] div_quo, div_rem;
  assign div_quo = 32'(a_sx / b_sx);
  assign div_rem = 32'(a_sx % b_sx);
`endif

  always_comb begin
    alu_res = '0;
    if (incPC) begin
      alu_res = {32'h0, bus + 32'd1};
    end else begin
      case (ALU_op)
        4'b0000: alu_res = {32'h0, y + bus};
        4'b0001: alu_res = {32'h0, y - bus};
        4'b0010: alu_res = {32'h0, y & bus};
        4'b0011: alu_res = {32'h0, y | bus};
        4'b0100: alu_res = {32'h0, y ^ bus};
        4'b0101: alu_res = a_sx * b_sx;
`ifdef DATAPATH_DIV_EN
        4'b0110: if (bus != 32'h0) alu_res = {div_rem, div_quo};
`endif
        4'b0111: alu_res = {32'h0, y >> shamt};
        4'b1000: alu_res = {32'h0, y_sra};
        4'b1001: alu_res = {32'h0, y << shamt};
        // Shift by 32 in a 32-bit context yields 0, so shamt = 0 rotates cleanly.
        4'b1010: alu_res = {32'h0, (y >> shamt) | (y << (6'd32 - {1'b0, shamt}))};
        4'b1011: alu_res = {32'h0, (y << shamt) | (y >> (6'd32 - {1'b0, shamt}))};
        4'b1100: alu_res = {32'h0, 32'h0 - bus};
        4'b1101: alu_res = {32'h0, ~bus};
        default: alu_res = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) gp[i] <= '0;
      pc  <= '0;
      ir  <= '0;
      y   <= '0;
      z   <= '0;
      hi  <= '0;
      lo  <= '0;
      mdr <= '0;
      mar <= '0;
    end else begin
      if (e_GP)  gp[GP_addr] <= bus;
      if (e_PC)  pc  <= bus;
      if (e_IR)  ir  <= bus;
      if (e_Y)   y   <= bus;
      if (e_Z)   z   <= alu_res;
      if (e_HI)  hi  <= bus;
      if (e_LO)  lo  <= bus;
      if (e_MDR) mdr <= MDR_read ? Mdatain : bus;
      if (e_MAR) mar <= bus;
    end
  end

  assign BusMuxOut = bus;
  assign PC_out    = pc;
  assign IR_out    = ir;
  assign MAR_out   = mar;
  assign HI_out    = hi;
  assign LO_out    = lo;

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - self-checking bench for datapath with behavioural model and random stimulus

module tb_datapath;

  logic        clock;
  logic        clear, incPC, MDR_read;
  logic [3:0]  GP_addr, ALU_op;
  logic [31:0] Mdatain;
  logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
  logic [4:0]  BusDataSelect;
  logic [31:0] BusMuxOut, PC_out, IR_out, MAR_out, HI_out, LO_out;

  int n_tests = 0;
  int n_fail  = 0;

  datapath dut (
    .clock(clock), .clear(clear), .incPC(incPC), .GP_addr(GP_addr), .Mdatain(Mdatain),
    .MDR_read(MDR_read), .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI),
    .e_LO(e_LO), .e_MDR(e_MDR), .e_MAR(e_MAR), .e_GP(e_GP), .ALU_op(ALU_op),
    .BusDataSelect(BusDataSelect), .BusMuxOut(BusMuxOut), .PC_out(PC_out), .IR_out(IR_out),
    .MAR_out(MAR_out), .HI_out(HI_out), .LO_out(LO_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model state
  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_y, m_hi, m_lo, m_mdr, m_mar;
  logic [63:0] m_z;
  bit          m_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_bus(input logic [4:0] sel);
    int s;
    s = int'(sel);
    if (s < 16) return m_r[s];
    if (s == 16) return m_hi;
    if (s == 17) return m_lo;
    if (s == 18) return m_z[63:32];
    if (s == 19) return m_z[31:0];
    if (s == 20) return m_pc;
    if (s == 21) return m_mdr;
    return 32'h0;
  endfunction

  function automatic logic [63:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic inc);
    int          ia, ib, sh;
    longint      sa, sb, q, rm, p;
    logic [31:0] t;
    if (inc) return {32'h0, b + 32'd1};
    ia = a; ib = b; sa = ia; sb = ib;
    sh = int'(b[4:0]);
    t  = a;
    case (op)
      4'd0: return {32'h0, 32'(sa + sb)};
      4'd1: return {32'h0, 32'(sa - sb)};
      4'd2: return {32'h0, a & b};
      4'd3: return {32'h0, a | b};
      4'd4: return {32'h0, a ^ b};
      4'd5: begin p = sa * sb; return p; end
      4'd6: begin
`ifdef DATAPATH_DIV_EN
        if (sb == 0) return 64'h0;
        q = sa / sb; rm = sa % sb;
        return {rm[31:0], q[31:0]};
`else
        q = 0; rm = 0;
        return 64'h0;
`endif
      end
      4'd7: begin for (int k = 0; k < sh; k++) t = {1'b0, t[31:1]}; return {32'h0, t}; end
      4'd8: begin for (int k = 0; k < sh; k++) t = {t[31], t[31:1]}; return {32'h0, t}; end
      4'd9: begin for (int k = 0; k < sh; k++) t = {t[30:0], 1'b0}; return {32'h0, t}; end
      4'd10: begin for (int k = 0; k < sh; k++) t = {t[0], t[31:1]}; return {32'h0, t}; end
      4'd11: begin for (int k = 0; k < sh; k++) t = {t[30:0], t[31]}; return {32'h0, t}; end
      4'd12: return {32'h0, 32'(-sb)};
      4'd13: return {32'h0, ~b};
      default: return 64'h0;
    endcase
  endfunction

  task automatic idle();
    clear = 0; incPC = 0; MDR_read = 0; e_PC = 0; e_IR = 0; e_Y = 0; e_Z = 0;
    e_HI = 0; e_LO = 0; e_MDR = 0; e_MAR = 0; e_GP = 0; ALU_op = 4'd0;
    BusDataSelect = 5'd31; GP_addr = 4'd0;
  endtask

  // One bus transfer: check the combinational bus, advance the model, check registered outputs.
  task automatic tick();
    logic [31:0] eb;
    logic [63:0] al;
    #1;
    eb = m_bus(BusDataSelect);
    if (m_valid) check("bus", {32'h0, BusMuxOut}, {32'h0, eb});
    al = m_alu(ALU_op, m_y, eb, incPC);
    if (clear) begin
      for (int i = 0; i < 16; i++) m_r[i] = '0;
      m_pc = 0; m_ir = 0; m_y = 0; m_z = 0; m_hi = 0; m_lo = 0; m_mdr = 0; m_mar = 0;
      m_valid = 1'b1;
    end else begin
      if (e_GP)  m_r[GP_addr] = eb;
      if (e_PC)  m_pc = eb;
      if (e_IR)  m_ir = eb;
      if (e_Y)   m_y = eb;
      if (e_Z)   m_z = al;
      if (e_HI)  m_hi = eb;
      if (e_LO)  m_lo = eb;
      if (e_MDR) m_mdr = MDR_read ? Mdatain : eb;
      if (e_MAR) m_mar = eb;
    end
    @(posedge clock);
    #1;
    if (m_valid) begin
      check("pc",  {32'h0, PC_out},  {32'h0, m_pc});
      check("ir",  {32'h0, IR_out},  {32'h0, m_ir});
      check("mar", {32'h0, MAR_out}, {32'h0, m_mar});
      check("hi",  {32'h0, HI_out},  {32'h0, m_hi});
      check("lo",  {32'h0, LO_out},  {32'h0, m_lo});
    end
    @(negedge clock);
  endtask

  task automatic load_gp(input logic [3:0] idx, input logic [31:0] val);
    idle(); Mdatain = val; MDR_read = 1; e_MDR = 1; tick();
    idle(); BusDataSelect = 5'd21; GP_addr = idx; e_GP = 1; tick();
  endtask

  // Y <- R[a]; Z <- Y op R[b]; LO <- Z low; HI <- Z high
  task automatic alu_to_hilo(input logic [4:0] ra, input logic [4:0] rb, input logic [3:0] op);
    idle(); BusDataSelect = ra; e_Y = 1; tick();
    idle(); BusDataSelect = rb; ALU_op = op; e_Z = 1; tick();
    idle(); BusDataSelect = 5'd19; e_LO = 1; tick();
    idle(); BusDataSelect = 5'd18; e_HI = 1; tick();
  endtask

  initial begin
    idle();
    Mdatain = 32'h0;
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_pc = 0; m_ir = 0; m_y = 0; m_z = 0; m_hi = 0; m_lo = 0; m_mdr = 0; m_mar = 0;
    @(negedge clock);

    // Reset
    idle(); clear = 1; tick();
    idle();
    for (int s = 0; s < 32; s++) begin
      BusDataSelect = 5'(s);
      #1;
      check("rst_bus", {32'h0, BusMuxOut}, 64'h0);
    end
    check("rst_pc", {32'h0, PC_out}, 64'h0);
    check("rst_hi", {32'h0, HI_out}, 64'h0);

    // Memory read into R2 / R6
    load_gp(4'd2, 32'd6);
    load_gp(4'd6, 32'd4);
    idle(); BusDataSelect = 5'd2; #1; check("r2_lit", {32'h0, BusMuxOut}, 64'd6);
    BusDataSelect = 5'd6; #1; check("r6_lit", {32'h0, BusMuxOut}, 64'd4);

    // Fetch
    idle(); BusDataSelect = 5'd20; e_MAR = 1; incPC = 1; e_Z = 1; tick();
    check("fetch_mar", {32'h0, MAR_out}, 64'h0);
    idle(); BusDataSelect = 5'd19; e_PC = 1; MDR_read = 1; e_MDR = 1; Mdatain = 32'h2A360000; tick();
    check("fetch_pc", {32'h0, PC_out}, 64'h1);
    idle(); BusDataSelect = 5'd21; e_IR = 1; tick();
    check("fetch_ir", {32'h0, IR_out}, 64'h2A360000);

    // MUL
    alu_to_hilo(5'd2, 5'd6, 4'b0101);
    check("mul_lo", {32'h0, LO_out}, 64'h18);
    check("mul_hi", {32'h0, HI_out}, 64'h0);
    load_gp(4'd2, 32'hFFFFFFFE);
    load_gp(4'd6, 32'd3);
    alu_to_hilo(5'd2, 5'd6, 4'b0101);
    check("muln_lo", {32'h0, LO_out}, 64'hFFFFFFFA);
    check("muln_hi", {32'h0, HI_out}, 64'hFFFFFFFF);

    // DIV
    load_gp(4'd2, 32'd7);
    load_gp(4'd6, 32'hFFFFFFFE);
    alu_to_hilo(5'd2, 5'd6, 4'b0110);
`ifdef DATAPATH_DIV_EN
    check("div_lo", {32'h0, LO_out}, 64'hFFFFFFFD);
    check("div_hi", {32'h0, HI_out}, 64'h1);
`else
    check("div_lo", {32'h0, LO_out}, 64'h0);
    check("div_hi", {32'h0, HI_out}, 64'h0);
`endif
    load_gp(4'd6, 32'd0);
    alu_to_hilo(5'd2, 5'd6, 4'b0110);
    check("div0_lo", {32'h0, LO_out}, 64'h0);
    check("div0_hi", {32'h0, HI_out}, 64'h0);

    // Clear priority over enables (bus carries R2 = 7)
    idle(); BusDataSelect = 5'd2; e_HI = 1; tick();
    check("hi_pre", {32'h0, HI_out}, 64'd7);
    idle(); clear = 1; BusDataSelect = 5'd2; e_GP = 1; GP_addr = 4'd3; e_HI = 1; tick();
    check("clr_hi", {32'h0, HI_out}, 64'h0);
    idle(); BusDataSelect = 5'd3; #1; check("clr_r3", {32'h0, BusMuxOut}, 64'h0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      clear         = ($urandom_range(0, 99) == 0);
      incPC         = ($urandom_range(0, 7) == 0);
      MDR_read      = $urandom_range(0, 1);
      e_PC          = ($urandom_range(0, 3) == 0);
      e_IR          = ($urandom_range(0, 3) == 0);
      e_Y           = ($urandom_range(0, 2) == 0);
      e_Z           = ($urandom_range(0, 1) == 0);
      e_HI          = ($urandom_range(0, 3) == 0);
      e_LO          = ($urandom_range(0, 3) == 0);
      e_MDR         = ($urandom_range(0, 2) == 0);
      e_MAR         = ($urandom_range(0, 3) == 0);
      e_GP          = ($urandom_range(0, 1) == 0);
      GP_addr       = 4'($urandom_range(0, 15));
      ALU_op        = 4'($urandom_range(0, 15));
      BusDataSelect = 5'($urandom_range(0, 31));
      Mdatain       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
